// File: rtl/aes_bridge_pkg.sv
// Shared types and constants for the FIFO-to-engine cipher bridge.
package aes_bridge_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StFeed,
    StWaitOut,
    StCapture,
    StDrain
  } state_e;

  // Field layout of an input FIFO word: {SOP, ..., key byte, data byte}
  localparam int unsigned DataLsb = 0;
  localparam int unsigned KeyLsb  = 8;

  localparam logic [15:0] ERR_TAG  = 16'hDEAD;
  localparam logic [15:0] STAT_TAG = 16'h5A5A;

  function automatic int unsigned sop_bit(input int unsigned data_width);
    return data_width - 1;
  endfunction

endpackage

// File: rtl/aes_bridge_pack.sv
// Output staging buffer: engine bytes are written one at a time and read back as packed
// FIFO words, byte k landing in word k/(DATA_WIDTH/8) at bit offset 8*(k%(DATA_WIDTH/8)).
module aes_bridge_pack #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BLOCK_BYTES = 16,
  localparam int unsigned NumWords   = BLOCK_BYTES / (DATA_WIDTH / 8),
  localparam int unsigned ByteIdxW   = $clog2(BLOCK_BYTES),
  localparam int unsigned WordIdxW   = $clog2(NumWords + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  byte_we_i,
  input  logic [ByteIdxW-1:0]   byte_idx_i,
  input  logic [7:0]            byte_i,
  input  logic                  wr_adv_i,
  input  logic                  wr_clr_i,
  output logic [WordIdxW-1:0]   wr_idx_o,
  output logic [DATA_WIDTH-1:0] word_o
);

  logic [BLOCK_BYTES*8-1:0] buf_q;
  logic [WordIdxW-1:0]      wr_idx_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_q    <= '0;
      wr_idx_q <= '0;
    end else begin
      for (int k = 0; k < int'(BLOCK_BYTES); k++) begin
        if (byte_we_i && (byte_idx_i == ByteIdxW'(k))) begin
          buf_q[k*8 +: 8] <= byte_i;
        end
      end
      if (wr_clr_i) begin
        wr_idx_q <= '0;
      end else if (wr_adv_i) begin
        wr_idx_q <= wr_idx_q + WordIdxW'(1);
      end
    end
  end

  // Indices past the result words (status slot) read as zero
  always_comb begin
    word_o = '0;
    for (int w = 0; w < int'(NumWords); w++) begin
      if (wr_idx_q == WordIdxW'(w)) begin
        word_o = buf_q[w*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign wr_idx_o = wr_idx_q;

endmodule

// File: rtl/aes_stream_bridge.sv
// Bridge between host FIFOs and a byte-serial block cipher core: buffers a block, streams it
// to the engine uninterrupted, packs results. Optional status word: AES_BRIDGE_STATUS_EN.
module aes_stream_bridge
  import aes_bridge_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BLOCK_BYTES = 16,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  data_empty,
  output logic                  data_rd,
  input  logic [DATA_WIDTH-1:0] data_din,
  input  logic                  data_full,
  output logic                  data_wr,
  output logic [DATA_WIDTH-1:0] data_dout,
  output logic [7:0]            eng_key,
  output logic [7:0]            eng_din,
  output logic                  eng_in_vld,
  input  logic [7:0]            eng_dout,
  input  logic                  eng_out_vld,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  blk_count,
  output logic                  timeout_err
);

  localparam int unsigned BytesPerWord = DATA_WIDTH / 8;
  localparam int unsigned NumWords     = BLOCK_BYTES / BytesPerWord;
  localparam int unsigned ByteIdxW     = $clog2(BLOCK_BYTES);
  localparam int unsigned WordIdxW     = $clog2(NumWords + 1);
  localparam int unsigned IdleW        = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned SopBit       = sop_bit(DATA_WIDTH);

  localparam logic [ByteIdxW-1:0] LastByte    = ByteIdxW'(BLOCK_BYTES - 1);
  localparam logic [WordIdxW-1:0] LastResWord = WordIdxW'(NumWords - 1);
  localparam logic [IdleW-1:0]    IdleLimit   = IdleW'(TIMEOUT_CYC - 1);
`ifdef AES_BRIDGE_STATUS_EN
  localparam logic [WordIdxW-1:0] StatusWord   = WordIdxW'(NumWords);
  localparam logic [WordIdxW-1:0] LastSuccWord = StatusWord;
`else
  localparam logic [WordIdxW-1:0] LastSuccWord = LastResWord;
`endif

  state_e                state_q, state_d;
  logic [ByteIdxW-1:0]   ld_idx_q, ld_idx_d;
  logic [ByteIdxW-1:0]   feed_idx_q, feed_idx_d;
  logic [ByteIdxW-1:0]   cap_idx_q, cap_idx_d;
  logic [IdleW-1:0]      idle_q, idle_d;
  logic [CNT_WIDTH-1:0]  blk_count_q, blk_count_d;
  logic                  tmo_q, tmo_d;
  logic                  derr_q, derr_d;
  logic [7:0]            eng_key_q, eng_key_d;
  logic [7:0]            eng_din_q, eng_din_d;
  logic                  eng_vld_q, eng_vld_d;

  logic [7:0]            in_key_q [BLOCK_BYTES];
  logic [7:0]            in_dat_q [BLOCK_BYTES];
  logic [ByteIdxW-1:0]   ld_wr_idx;

  logic                  cap_we;
  logic                  wr_clr;
  logic [WordIdxW-1:0]   wr_idx;
  logic [DATA_WIDTH-1:0] pack_word;
  logic [WordIdxW-1:0]   last_word;

  function automatic logic [DATA_WIDTH-1:0] tag_word(input logic [15:0]          tag,
                                                     input logic [CNT_WIDTH-1:0] cnt);
    logic [DATA_WIDTH-1:0] w;
    w = '0;
    w[DATA_WIDTH-1 -: 16] = tag;
    for (int b = 0; b < int'(DATA_WIDTH) - 16; b++) begin
      if (b < int'(CNT_WIDTH)) w[b] = cnt[b];
    end
    return w;
  endfunction

  assign data_rd   = (state_q == StLoad) && !data_empty;
  assign data_wr   = (state_q == StDrain) && !data_full;
  assign last_word = derr_q ? '0 : LastSuccWord;

  always_comb begin
    state_d     = state_q;
    ld_idx_d    = ld_idx_q;
    feed_idx_d  = feed_idx_q;
    cap_idx_d   = cap_idx_q;
    idle_d      = idle_q;
    blk_count_d = blk_count_q;
    tmo_d       = tmo_q;
    derr_d      = derr_q;
    eng_key_d   = '0;
    eng_din_d   = '0;
    eng_vld_d   = 1'b0;
    ld_wr_idx   = ld_idx_q;
    cap_we      = 1'b0;
    wr_clr      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!data_empty) state_d = StLoad;
      end
      StLoad: begin
        if (!data_empty) begin
          if (data_din[SopBit] && (ld_idx_q != '0)) begin
            // Start-of-packet mid-block: drop the partial block and resync on this pair
            ld_wr_idx = '0;
            ld_idx_d  = ByteIdxW'(1);
          end else if (ld_idx_q == LastByte) begin
            ld_idx_d   = '0;
            feed_idx_d = '0;
            state_d    = StFeed;
          end else begin
            ld_idx_d = ld_idx_q + ByteIdxW'(1);
          end
        end
      end
      StFeed: begin
        eng_vld_d = 1'b1;
        eng_key_d = in_key_q[feed_idx_q];
        eng_din_d = in_dat_q[feed_idx_q];
        if (feed_idx_q == LastByte) begin
          feed_idx_d = '0;
          cap_idx_d  = '0;
          idle_d     = '0;
          state_d    = StWaitOut;
        end else begin
          feed_idx_d = feed_idx_q + ByteIdxW'(1);
        end
      end
      StWaitOut, StCapture: begin
        if (eng_out_vld) begin
          cap_we  = 1'b1;
          idle_d  = '0;
          state_d = StCapture;
          if (cap_idx_q == LastByte) begin
            cap_idx_d = '0;
            derr_d    = 1'b0;
            state_d   = StDrain;
          end else begin
            cap_idx_d = cap_idx_q + ByteIdxW'(1);
          end
        end else if (idle_q == IdleLimit) begin
          tmo_d     = 1'b1;
          derr_d    = 1'b1;
          cap_idx_d = '0;
          idle_d    = '0;
          state_d   = StDrain;
        end else begin
          idle_d = idle_q + IdleW'(1);
        end
      end
      StDrain: begin
        if (data_wr) begin
          if (!derr_q && (wr_idx == LastResWord)) begin
            blk_count_d = blk_count_q + CNT_WIDTH'(1);
          end
          if (wr_idx == last_word) begin
            wr_clr  = 1'b1;
            derr_d  = 1'b0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      ld_idx_q    <= '0;
      feed_idx_q  <= '0;
      cap_idx_q   <= '0;
      idle_q      <= '0;
      blk_count_q <= '0;
      tmo_q       <= 1'b0;
      derr_q      <= 1'b0;
      eng_key_q   <= '0;
      eng_din_q   <= '0;
      eng_vld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_idx_q    <= ld_idx_d;
      feed_idx_q  <= feed_idx_d;
      cap_idx_q   <= cap_idx_d;
      idle_q      <= idle_d;
      blk_count_q <= blk_count_d;
      tmo_q       <= tmo_d;
      derr_q      <= derr_d;
      eng_key_q   <= eng_key_d;
      eng_din_q   <= eng_din_d;
      eng_vld_q   <= eng_vld_d;
    end
  end

  // Pure data storage; validity is tracked by ld_idx_q and the FSM
  always_ff @(posedge clock) begin
    if (data_rd) begin
      in_key_q[ld_wr_idx] <= data_din[KeyLsb +: 8];
      in_dat_q[ld_wr_idx] <= data_din[DataLsb +: 8];
    end
  end

  aes_bridge_pack #(
    .DATA_WIDTH  (DATA_WIDTH),
    .BLOCK_BYTES (BLOCK_BYTES)
  ) u_pack (
    .clk_i      (clock),
    .rst_i      (reset),
    .byte_we_i  (cap_we),
    .byte_idx_i (cap_idx_q),
    .byte_i     (eng_dout),
    .wr_adv_i   (data_wr),
    .wr_clr_i   (wr_clr),
    .wr_idx_o   (wr_idx),
    .word_o     (pack_word)
  );

  always_comb begin
    data_dout = pack_word;
    if (derr_q) begin
      data_dout = tag_word(ERR_TAG, blk_count_q);
    end
`ifdef AES_BRIDGE_STATUS_EN
    else if (wr_idx == StatusWord) begin
      data_dout = tag_word(STAT_TAG, blk_count_q);
    end
`endif
  end

  generate
    if (DATA_WIDTH > 17) begin : g_unused_din
      logic unused_din;
      assign unused_din = ^data_din[DATA_WIDTH-2:16];
    end
  endgenerate

  assign eng_key     = eng_key_q;
  assign eng_din     = eng_din_q;
  assign eng_in_vld  = eng_vld_q;
  assign busy        = (state_q != StIdle);
  assign blk_count   = blk_count_q;
  assign timeout_err = tmo_q;

endmodule
